// File: rtl/seg_scan_driver_if.sv
// Value/control inputs and display pin outputs of seg_scan_driver.
interface seg_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                load;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                blank_en;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_done;

  modport master (output load, value, dp_in, blank_en,
                  input  seg, dig_sel, frame_done);
  modport slave  (input  load, value, dp_in, blank_en,
                  output seg, dig_sel, frame_done);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit seven-segment driver with double-buffered value.
// Define SEG_SCAN_HEX_EN to decode nibbles A..F as hex glyphs (default: dash).
module seg_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  seg_scan_driver_if.slave bus
);
  localparam int unsigned       IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned       PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [7:0]        SEG_IDLE = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_IDLE = {DIGITS{DIG_ACTIVE_LOW}};

  logic [PRE_W-1:0]            pre;
  logic [IDX_W-1:0]            idx;
  logic                        tick;
  logic                        boundary;
  logic [DIGITS-1:0][3:0]      shadow_val;
  logic [DIGITS-1:0]           shadow_dp;
  logic [DIGITS-1:0][3:0]      pend_val;
  logic [DIGITS-1:0]           pend_dp;
  logic                        pend;
  logic [DIGITS-1:0]           zero_from;
  logic                        blank;
  logic [7:0]                  seg_raw;
  logic [DIGITS-1:0]           dig_raw;
  logic [7:0]                  seg_q;
  logic [DIGITS-1:0]           dig_q;
  logic                        frame_q;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b1111110;
      4'h1:    decode = 7'b0110000;
      4'h2:    decode = 7'b1101101;
      4'h3:    decode = 7'b1111001;
      4'h4:    decode = 7'b0110011;
      4'h5:    decode = 7'b1011011;
      4'h6:    decode = 7'b1011111;
      4'h7:    decode = 7'b1110000;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1111011;
`ifdef SEG_SCAN_HEX_EN
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b0011111;
      4'hC:    decode = 7'b1001110;
      4'hD:    decode = 7'b0111101;
      4'hE:    decode = 7'b1001111;
      default: decode = 7'b1000111;
`else
      default: decode = 7'b0000001;
`endif
    endcase
  endfunction

  always_comb begin
    tick     = (pre == PRE_LAST);
    boundary = tick && (idx == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (tick) begin
      pre <= '0;
      idx <= boundary ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Shadow only changes on a frame boundary, so a frame never mixes values;
  // a load landing on the boundary itself bypasses the pending stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend       <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
      end else if (pend) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
      end
      pend <= 1'b0;
    end else if (bus.load) begin
      pend_val <= bus.value;
      pend_dp  <= bus.dp_in;
      pend     <= 1'b1;
    end
  end

  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    logic run_zero;
    run_zero  = 1'b1;
    zero_from = '0;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      run_zero       = run_zero && (shadow_val[i-1] == 4'h0);
      zero_from[i-1] = run_zero;
    end
  end

  always_comb begin
    blank   = bus.blank_en && (idx != '0) && zero_from[idx];
    seg_raw = {blank ? 7'b0000000 : decode(shadow_val[idx]), shadow_dp[idx]};
    dig_raw = DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= SEG_IDLE;
      dig_q   <= DIG_IDLE;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_raw ^ SEG_IDLE;
      dig_q   <= dig_raw ^ DIG_IDLE;
      frame_q <= boundary;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_done = frame_q;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multi-digit multiplexed seven-segment display driver, the successor to the single-digit registered BCD decoder. It holds a DIGITS-wide packed nibble value in a double-buffered register and time-multiplexes the digits onto one shared segment bus with a one-hot digit select. It also provides decimal points, leading-zero blanking, configurable output polarity and a frame-done strobe. It sits between the datapath that produces display values and the board's display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..16)
SCAN_DIV, 1000, clk cycles per digit slot (>=1)
SEG_ACTIVE_LOW, 0, 1 = segment outputs inverted (common-anode)
DIG_ACTIVE_LOW, 1, 1 = digit select outputs inverted

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  capture value/dp_in this cycle
value  in  4*DIGITS  packed nibbles; nibble i ([4i+3:4i]) drives digit i; digit 0 is least significant
dp_in  in  DIGITS  decimal point per digit
blank_en  in  1  enable leading-zero suppression
seg  out  8  segments abcdefgh, bit7=a ... bit1=g, bit0=h (dp)
dig_sel  out  DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse at frame boundary

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=0, shadow value/dp=0, pending=0, pend flag=0, frame_done=0; seg and dig_sel at inactive level (all 0 if polarity parameter is 0, else all 1).
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick is asserted in the cycle where prescaler==SCAN_DIV-1. SCAN_DIV=1 gives tick every cycle.
- On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Frame boundary is a tick with idx==DIGITS-1. On a frame boundary, frame_done=1 for the next cycle; it is 0 otherwise.
- Double buffer:
  - load outside a boundary: pending <= value/dp_in; pend <= 1. A later load overwrites pending.
  - At a boundary with pend=1 and no load: shadow <= pending; pend <= 0.
  - load in the boundary cycle: shadow <= value/dp_in directly; pend <= 0.
  - A displayed frame never mixes old and new values.
- Decode of nibble n = shadow[4*idx+3:4*idx], giving abcdefg in bits 7..1:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- seg[0] = shadow dp bit for idx. The dp bit is kept even when the digit is blanked.
- Leading-zero blanking: when blank_en=1, digit i>0 is blanked (abcdefg=0) if nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. blank_en is sampled live, not buffered.
- Outputs are registered. seg and dig_sel reflect idx and shadow as of the previous cycle, giving 1-cycle latency from an idx or shadow change to the pins.
- dig_sel has exactly one bit active (bit idx) at all times after the first post-reset cycle.
- Polarity inversion is applied after decode, dp and blanking.
- Deasserting rst_n mid-scan forces inactive outputs immediately. After release, scanning restarts at digit 0 with shadow=0.

Optional Feature:
Macro: SEG_SCAN_HEX_EN
- Defined: nibbles 10..15 decode as A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Undefined: nibbles 10..15 decode as dash, g only (0000001).
- In both cases blanking treats only nibble 0 as zero.

Test Plan:
- DIGITS=4, SCAN_DIV=4, both polarities 0, reset held then released → seg=0 and dig_sel=0 during reset. Afterwards dig_sel cycles 0001,0010,0100,1000 every 4 cycles, seg=11111100, and frame_done pulses once per 16 cycles.
- Load 16'h1234 in mid-frame → the current frame still shows 0. From the next frame, digit0 shows 4 (01100110), digit1 shows 3 (11110010), digit2 shows 2 (11011010), digit3 shows 1 (01100000). Also load exactly in the boundary cycle → the new value appears in the very next digit-0 slot.
- value=16'h0050, blank_en=1, dp_in=4'b1000 → digit3 seg=00000001, digit2 seg=00000000, digit1=10110110, digit0=11111100. With blank_en=0 → digits 3 and 2 show 0.
- value nibble0=4'hA → 11101110 with SEG_SCAN_HEX_EN defined, 00000010 without.
- SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value=8 on digit 0 → seg=00000001 and dig_sel=1110 during digit 0.
- rst_n pulsed low while idx=2 → outputs go inactive asynchronously. After release, scan restarts at digit 0 and the display shows 0.
